// File: rtl/sv_net1_tester_if.sv
// Signal bundle between the net tester, its controller and the net under test.
// The tester sits on the slave side: it takes start/abort and the net outputs, and drives everything else.
interface sv_net1_tester_if;
    logic       start;
    logic       abort;
    logic       x;
    logic       y;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] error_count;
    logic       fail_valid;
    logic [3:0] first_fail;

    modport slave (
        input  start, abort, x, y,
        output a, b, c, d, busy, done, pass, error_count, fail_valid, first_fail
    );

    modport master (
        output start, abort, x, y,
        input  a, b, c, d, busy, done, pass, error_count, fail_valid, first_fail
    );
endinterface

// File: rtl/sv_net1_tester.sv
// Self-running exhaustive tester for the 4-in/2-out net: steps all 16 vectors,
// waits SETTLE_CYCLES per vector, then checks x/y against the reference function.
module sv_net1_tester #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    sv_net1_tester_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [7:0] LP_SETTLE = 8'(SETTLE_CYCLES);
    localparam state_t     LP_FIRST  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t     r_state;
    logic [3:0] r_vec;
    logic [7:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [4:0] r_err;
    logic       r_fail_valid;
    logic [3:0] r_first;

    logic       w_x_exp;
    logic       w_y_exp;
    logic       w_mismatch;
    logic [4:0] w_err_next;
    logic       w_go;

    // r_vec is {a,b,c,d}
    assign w_x_exp    = (r_vec[3] & r_vec[2]) | (~r_vec[3] & ~r_vec[1]) | (r_vec[3] & ~r_vec[0]);
    assign w_y_exp    = r_vec[2];
    assign w_mismatch = (bus.x != w_x_exp) | (bus.y != w_y_exp);
    assign w_err_next = r_err + {4'd0, w_mismatch};
    assign w_go       = bus.start & ((r_state == IDLE) | (r_state == DONE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_vec        <= 4'd0;
            r_cnt        <= 8'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= 5'd0;
            r_fail_valid <= 1'b0;
            r_first      <= 4'd0;
        end else if (bus.abort) begin
            // partial error results stay visible until the next start
            r_state <= IDLE;
            r_vec   <= 4'd0;
            r_cnt   <= 8'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else if (w_go) begin
            r_state      <= LP_FIRST;
            r_vec        <= 4'd0;
            r_cnt        <= LP_SETTLE;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= 5'd0;
            r_fail_valid <= 1'b0;
            r_first      <= 4'd0;
        end else begin
            case (r_state)
                SETTLE: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) r_state <= SAMPLE;
                end
                SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_first      <= r_vec;
                        r_fail_valid <= 1'b1;
                    end
                    if (r_vec == 4'd15) begin
                        r_state <= DONE;
                        r_vec   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 5'd0);
                    end else begin
                        r_vec   <= r_vec + 4'd1;
                        r_cnt   <= LP_SETTLE;
                        r_state <= LP_FIRST;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d} = r_vec;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.error_count = r_err;
    assign bus.fail_valid  = r_fail_valid;
    assign bus.first_fail  = r_first;
endmodule

// File: tb/tb_sv_net1_tester.sv
// Directed bench: two testers (settle 2 and settle 0) each driving a behavioural
// net whose x/y can be faulted, with hand-tabulated expected results.
module tb_sv_net1_tester;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   mode0 = 0;
    int   mode1 = 0;

    // x for vectors 15..0, tabulated by hand from ab | a'c' | ad'
    localparam logic [15:0] X_TABLE = 16'hF533;

    always #5 clock = ~clock;

    sv_net1_tester_if if0 ();
    sv_net1_tester_if if1 ();

    sv_net1_tester #(.SETTLE_CYCLES(2)) dut0 (.clock(clock), .reset(reset), .bus(if0));
    sv_net1_tester #(.SETTLE_CYCLES(0)) dut1 (.clock(clock), .reset(reset), .bus(if1));

    // mode 0 good, 1 y stuck 0, 2 x inverted, 3 x forced 1 at vector 1001
    function automatic logic [1:0] net(input logic [3:0] v, input int mode);
        logic xx, yy;
        xx = X_TABLE[v];
        yy = v[2];
        if (mode == 1) yy = 1'b0;
        if (mode == 2) xx = ~xx;
        if (mode == 3 && v == 4'd9) xx = 1'b1;
        return {xx, yy};
    endfunction

    always_comb {if0.x, if0.y} = net({if0.a, if0.b, if0.c, if0.d}, mode0);
    always_comb {if1.x, if1.y} = net({if1.a, if1.b, if1.c, if1.d}, mode1);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs0();
        return {if0.a, if0.b, if0.c, if0.d, if0.busy, if0.done, if0.pass,
                if0.error_count, if0.fail_valid, if0.first_fail};
    endfunction

    task automatic start0();
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
    endtask

    task automatic wait_done0(input string tag);
        int n = 0;
        while (!if0.done && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(if0.done), 32'd1);
    endtask

    initial begin
        int n;
        bit pulsed;
        if0.start = 1'b0; if0.abort = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0;
        #2;
        chk("reset_outs0", outs0(), 32'd0);
        chk("reset_busy1", {if1.busy, if1.done, if1.a, if1.b, if1.c, if1.d}, 32'd0);
        #10 reset = 1'b0;
        tick();
        chk("idle_after_reset", outs0(), 32'd0);

        // good net, settle 2: 48 busy cycles, each vector held 3
        start0();
        for (int k = 0; k < 48; k++) begin
            chk($sformatf("run1_cyc%0d", k), {if0.busy, if0.a, if0.b, if0.c, if0.d}, {27'd0, 1'b1, 4'(k / 3)});
            tick();
        end
        chk("run1_done", {if0.busy, if0.done, if0.pass}, 32'b011);
        chk("run1_err", {if0.error_count, if0.fail_valid}, 32'd0);
        chk("run1_vec_idle", {if0.a, if0.b, if0.c, if0.d}, 32'd0);

        // y stuck at 0
        mode0 = 1;
        start0();
        chk("run2_done_clear", {if0.busy, if0.done}, 32'b10);
        wait_done0("run2_done");
        chk("run2_err", if0.error_count, 32'd8);
        chk("run2_first", {if0.fail_valid, if0.first_fail}, {27'd0, 1'b1, 4'b0100});
        chk("run2_pass", if0.pass, 32'd0);

        // x inverted
        mode0 = 2;
        start0();
        wait_done0("run3_done");
        chk("run3_err", if0.error_count, 32'd16);
        chk("run3_first", {if0.fail_valid, if0.first_fail, if0.pass}, {26'd0, 1'b1, 4'b0000, 1'b0});

        // single fault at 1001
        mode0 = 3;
        start0();
        wait_done0("run3b_done");
        chk("run3b_err", if0.error_count, 32'd1);
        chk("run3b_first", {if0.fail_valid, if0.first_fail, if0.pass}, {26'd0, 1'b1, 4'b1001, 1'b0});

        // settle 0: a new vector each cycle, done on the 17th
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("fast_cyc%0d", k), {if1.busy, if1.done, if1.a, if1.b, if1.c, if1.d}, {26'd0, 2'b10, 4'(k)});
            tick();
        end
        chk("fast_done", {if1.busy, if1.done, if1.pass, if1.error_count}, {24'd0, 3'b011, 5'd0});

        // abort at vector 0111
        mode0 = 0;
        start0();
        n = 0;
        while ({if0.a, if0.b, if0.c, if0.d} != 4'd7 && n < 100) begin tick(); n++; end
        chk("abort_reach7", {if0.a, if0.b, if0.c, if0.d}, 32'd7);
        if0.abort = 1'b1;
        tick();
        if0.abort = 1'b0;
        chk("abort_idle", {if0.busy, if0.done, if0.pass, if0.a, if0.b, if0.c, if0.d}, 32'd0);
        if0.start = 1'b1; if0.abort = 1'b1;
        tick();
        if0.start = 1'b0; if0.abort = 1'b0;
        chk("abort_wins", {if0.busy, if0.done}, 32'd0);
        tick();
        chk("abort_stays_idle", if0.busy, 32'd0);
        start0();
        wait_done0("abort_rerun_done");
        chk("abort_rerun_pass", {if0.pass, if0.error_count}, {26'd0, 1'b1, 5'd0});

        // start pulse mid-run at 0101 must not restart
        start0();
        n = 1;
        pulsed = 0;
        while (if0.busy && n < 200) begin
            if (!pulsed && {if0.a, if0.b, if0.c, if0.d} == 4'd5) begin
                if0.start = 1'b1;
                pulsed = 1;
            end
            tick();
            if0.start = 1'b0;
            if (if0.busy) n++;
        end
        chk("restart_ignored_len", n, 32'd48);
        chk("restart_ignored_pass", {if0.done, if0.pass}, 32'b11);

        // asynchronous reset mid-run
        start0();
        repeat (10) tick();
        chk("pre_reset_busy", if0.busy, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outs", outs0(), 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        chk("post_reset_idle", outs0(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
